// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared widths, class encodings, field positions for decode
package decode_pkg;
  localparam int WORD   = 32;
  localparam int INST   = 32;
  localparam int ADDR   = 32;
  localparam int W_RD   = 4;
  localparam int W_DOPC = 6;
  localparam int W_OPC  = 4;

  typedef enum logic [3:0] {
    CLS_INTE   = 4'd0,
    CLS_SHIFT  = 4'd1,
    CLS_LOGIC  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5
  } cls_e;

  localparam int DOPC_INTE   = 5;
  localparam int DOPC_SHIFT  = 4;
  localparam int DOPC_LOGIC  = 3;
  localparam int DOPC_LOAD   = 2;
  localparam int DOPC_STORE  = 1;
  localparam int DOPC_BRANCH = 0;

  localparam int F_CLS_LSB = 28;
  localparam int F_OPC_LSB = 24;
  localparam int F_RD_LSB  = 20;
  localparam int F_RS_LSB  = 16;
  localparam int F_IMM_SEL = 15;
  localparam int F_IMM_W   = 15;

  function automatic logic [W_DOPC-1:0] dopc_of(input logic [3:0] cls);
    logic [W_DOPC-1:0] d;
    d = '0;
    case (cls)
      CLS_INTE:   d[DOPC_INTE]   = 1'b1;
      CLS_SHIFT:  d[DOPC_SHIFT]  = 1'b1;
      CLS_LOGIC:  d[DOPC_LOGIC]  = 1'b1;
      CLS_LOAD:   d[DOPC_LOAD]   = 1'b1;
      CLS_STORE:  d[DOPC_STORE]  = 1'b1;
      CLS_BRANCH: d[DOPC_BRANCH] = 1'b1;
      default:    d = '0;
    endcase
    return d;
  endfunction

  function automatic logic cls_legal(input logic [3:0] cls);
    return cls <= CLS_BRANCH;
  endfunction

  function automatic logic cls_writes_back(input logic [3:0] cls);
    return cls <= CLS_LOAD;
  endfunction
endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 16-entry register file, two read ports with write-through bypass
module regfile
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [W_RD-1:0] i_wa,
  input  logic [WORD-1:0] i_wd,
  input  logic [W_RD-1:0] i_ra0,
  input  logic [W_RD-1:0] i_ra1,
  output logic [WORD-1:0] o_rd0,
  output logic [WORD-1:0] o_rd1
);
  localparam int NREG = 1 << W_RD;

  logic [WORD-1:0] r_mem [NREG];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && i_wa != '0) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd0 = '0;
    o_rd1 = '0;
    if (i_ra0 != '0) o_rd0 = (i_we && i_wa == i_ra0) ? i_wd : r_mem[i_ra0];
    if (i_ra1 != '0) o_rd1 = (i_we && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
  end
endmodule

// File: rtl/decode.sv
// rtl/decode.sv - decode stage: field split, operand read, hazard bubble, registered issue
module decode
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  output logic              stall_o,
  input  logic [INST-1:0]   inst_i,
  input  logic [ADDR-1:0]   addr_i,
  input  logic              stall_i,
  output logic              v_o,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   rd_num_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [ADDR-1:0]   origaddr_o,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   rd_num_i,
  input  logic [WORD-1:0]   rd_data_i,
  output logic              illegal_o
);
  logic [3:0]         w_cls;
  logic [W_OPC-1:0]   w_opc;
  logic [W_RD-1:0]    w_rd;
  logic [W_RD-1:0]    w_rs;
  logic               w_imm_sel;
  logic [F_IMM_W-1:0] w_imm;
  logic [WORD-1:0]    w_rs_val;
  logic [WORD-1:0]    w_rd_val;
  logic               w_hazard;
  logic               w_accept;
  logic               w_legal;

  logic              r_v;
  logic [WORD-1:0]   r_src;
  logic [WORD-1:0]   r_dest;
  logic              r_wb;
  logic [W_RD-1:0]   r_rd;
  logic [W_DOPC-1:0] r_dopc;
  logic [W_OPC-1:0]  r_opc;
  logic [ADDR-1:0]   r_addr;
  logic              r_ill;

  assign w_cls     = inst_i[F_CLS_LSB +: 4];
  assign w_opc     = inst_i[F_OPC_LSB +: W_OPC];
  assign w_rd      = inst_i[F_RD_LSB +: W_RD];
  assign w_rs      = inst_i[F_RS_LSB +: W_RD];
  assign w_imm_sel = inst_i[F_IMM_SEL];
  assign w_imm     = inst_i[F_IMM_W-1:0];
  assign w_legal   = cls_legal(w_cls);

  regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_we  (wb_i),
    .i_wa  (rd_num_i),
    .i_wd  (rd_data_i),
    .i_ra0 (w_rs),
    .i_ra1 (w_rd),
    .o_rd0 (w_rs_val),
    .o_rd1 (w_rd_val)
  );

  // The instruction in flight has not written back yet; hold the new one a cycle
  // so its result arrives through the regfile bypass.
  assign w_hazard = r_v & r_wb & (r_rd != '0) &
                    ((r_rd == w_rd) | (~w_imm_sel & (r_rd == w_rs)));
  assign stall_o  = stall_i | (v_i & w_hazard);
  assign w_accept = v_i & ~stall_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v    <= 1'b0;
      r_src  <= '0;
      r_dest <= '0;
      r_wb   <= 1'b0;
      r_rd   <= '0;
      r_dopc <= '0;
      r_opc  <= '0;
      r_addr <= '0;
      r_ill  <= 1'b0;
    end else begin
      r_ill <= w_accept & ~w_legal;
      if (!stall_i) begin
        if (w_accept && w_legal) begin
          r_v    <= 1'b1;
          r_src  <= w_imm_sel ? {{(WORD-F_IMM_W){w_imm[F_IMM_W-1]}}, w_imm} : w_rs_val;
          r_dest <= w_rd_val;
          r_wb   <= cls_writes_back(w_cls);
          r_rd   <= w_rd;
          r_dopc <= dopc_of(w_cls);
          r_opc  <= w_opc;
          r_addr <= addr_i;
        end else begin
          r_v  <= 1'b0;
          r_wb <= 1'b0;
        end
      end
    end
  end

  assign v_o        = r_v;
  assign src_o      = r_src;
  assign dest_o     = r_dest;
  assign wb_o       = r_wb;
  assign rd_num_o   = r_rd;
  assign dopc_o     = r_dopc;
  assign opc_o      = r_opc;
  assign origaddr_o = r_addr;
  assign illegal_o  = r_ill;
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameters SHALL be:
- WORD, 32, data word width.
- INST, 32, instruction width.
- ADDR, 32, instruction address width.
- W_RD, 4, register index width (16 registers).
- W_DOPC, 6, one-hot decoded class width.
- W_OPC, 4, sub-opcode width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- v_i  in  1  fetch instruction valid.
- stall_o  out  1  fetch must hold inst_i/addr_i/v_i.
- inst_i  in  INST  instruction.
- addr_i  in  ADDR  instruction address.
- stall_i  in  1  execute stage cannot accept.
- v_o  out  1  execute-bound valid.
- src_o  out  WORD  source operand.
- dest_o  out  WORD  destination operand value.
- wb_o  out  1  result to be written back.
- rd_num_o  out  W_RD  destination register index.
- dopc_o  out  W_DOPC  one-hot class: bit5 inte, bit4 shift, bit3 logic, bit2 load, bit1 store, bit0 branch.
- opc_o  out  W_OPC  sub-opcode.
- origaddr_o  out  ADDR  address of the issued instruction.
- wb_i  in  1  writeback enable from execute.
- rd_num_i  in  W_RD  writeback index.
- rd_data_i  in  WORD  writeback data.
- illegal_o  out  1  one-cycle pulse on an illegal class.
REQ-003 Clock SHALL be clk; reset SHALL be rst, asynchronous, active-high.

Function
REQ-004 Instruction fields SHALL be: [31:28] class, [27:24] opc, [23:20] rd, [19:16] rs, [15] imm_sel, [14:0] imm.
REQ-005 Class encodings SHALL be: 0 inte, 1 shift, 2 logic, 3 load, 4 store, 5 branch; 6-15 are illegal.
REQ-006 The block SHALL hold a 16 x WORD register file; register 0 SHALL read as 0 and ignore writes.
REQ-007 The register file SHALL write rd_data_i to rd_num_i on every rising edge with wb_i=1, regardless of stall.
REQ-008 A read whose index equals rd_num_i (nonzero) while wb_i=1 SHALL return rd_data_i in the same cycle (write-through bypass).
REQ-009 The src value SHALL be the 15-bit imm sign-extended to WORD when imm_sel=1, otherwise reg[rs]; the dest value SHALL be reg[rd].
REQ-010 The wb value SHALL be 1 for the inte, shift, logic and load classes and 0 for the store and branch classes.
REQ-011 All execute-bound outputs SHALL be registered, giving 1-cycle latency from acceptance to v_o.
REQ-012 An input SHALL be accepted on an edge where v_i=1 and stall_o=0.
REQ-013 A hazard SHALL exist when v_o=1, wb_o=1, rd_num_o!=0 and rd_num_o equals the new instruction's rd, or equals its rs when imm_sel=0.
REQ-014 stall_o SHALL equal stall_i OR (v_i AND hazard).
REQ-015 While stall_i=1, all output registers SHALL hold their values.
REQ-016 While there is a hazard and stall_i=0, the edge SHALL load v_o=0 (bubble), then the same instruction SHALL issue on the following edge using the bypass.
REQ-017 On an accepted illegal class, the edge SHALL load v_o=0 and wb_o=0, and illegal_o SHALL pulse high for one cycle.
REQ-018 With stall_i=0 and no accepted input, the edge SHALL load v_o=0 and wb_o=0; the other output fields are don't-care.

Reset
REQ-019 During rst, every output register, all 16 registers and illegal_o SHALL be 0; stall_o SHALL follow REQ-014.
REQ-020 Asserting rst mid-stall or mid-bubble SHALL discard the pending instruction, and no issue SHALL occur after release until a fresh acceptance.

Structure
REQ-021 A shared package SHALL hold WORD, INST, ADDR, W_RD, W_DOPC, W_OPC, the class encodings, the dopc bit positions and the instruction field positions.
REQ-022 The register file with bypass SHALL be the single sub-module, named regfile (two read ports, one write port).

Verification
REQ-023 After reset, the bench SHALL send inte (opc=2, rd=3, rs=0, imm_sel=1, imm=0x7FFF) and check next cycle: v_o=1, src_o=0xFFFFFFFF, dopc_o=6'b100000, wb_o=1, rd_num_o=3.
REQ-024 With wb_i=1, rd_num_i=5, rd_data_i=0x1234 and the same cycle an accepted instruction with rs=5, imm_sel=0, the bench SHALL check src_o=0x00001234 next cycle.
REQ-025 The bench SHALL send back-to-back logic rd=4, then inte rs=4, and check stall_o=1 for one cycle, one bubble (v_o=0), then the second instruction issues with the bypassed value.
REQ-026 The bench SHALL hold stall_i=1 for 3 cycles with v_o=1 and check that all outputs are frozen and stall_o=1, then that the next instruction issues 1 cycle after release.
REQ-027 The bench SHALL send class 9 and check illegal_o pulses for 1 cycle with v_o=0; it SHALL also write reg 0 with 0xDEAD and check that a read of reg 0 returns 0.
REQ-028 The bench SHALL assert rst during a hazard bubble and check that all outputs are 0 and that nothing issues after release until v_i=1.
